// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, phase codes and complex sample type for the pipelined FFT stages
package fft_pkg;

  localparam int DATA_W = 24;
  localparam int FRAC_W = 8;

  // Controller phase codes; 2'd3 is never issued by a healthy controller
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;
  localparam logic [1:0] ST_BAD  = 2'd3;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/sdf_r2_stage_64_if.sv
// rtl/sdf_r2_stage_64_if.sv - sample/phase/twiddle bundle between the twiddle controller and an SDF stage
interface sdf_r2_stage_64_if;
  import fft_pkg::*;

  logic                     in_valid;
  logic signed [DATA_W-1:0] din_r;
  logic signed [DATA_W-1:0] din_i;
  logic [1:0]               state;
  logic signed [DATA_W-1:0] w_r;
  logic signed [DATA_W-1:0] w_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r;
  logic signed [DATA_W-1:0] dout_i;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );

endinterface

// File: rtl/cmul_q.sv
// rtl/cmul_q.sv - combinational complex multiply by a fixed-point twiddle, floor-shifted and truncated
module cmul_q #(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [DATA_W-1:0] p_r,
  output logic signed [DATA_W-1:0] p_i
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;
  logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc;
  logic signed [PW:0]   sum_re, sum_im;
  logic                 unused_bits;

  assign ar_x = {{DATA_W{a_r[DATA_W-1]}}, a_r};
  assign ai_x = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign wr_x = {{DATA_W{w_r[DATA_W-1]}}, w_r};
  assign wi_x = {{DATA_W{w_i[DATA_W-1]}}, w_i};

  assign p_ac = ar_x * wr_x;
  assign p_bd = ai_x * wi_x;
  assign p_ad = ar_x * wi_x;
  assign p_bc = ai_x * wr_x;

  assign sum_re = {p_ac[PW-1], p_ac} - {p_bd[PW-1], p_bd};
  assign sum_im = {p_ad[PW-1], p_ad} + {p_bc[PW-1], p_bc};

  // Taking bits above FRAC_W is an arithmetic shift (floor) followed by truncation
  assign p_r = sum_re[FRAC_W +: DATA_W];
  assign p_i = sum_im[FRAC_W +: DATA_W];

  assign unused_bits = ^{sum_re[PW:FRAC_W+DATA_W], sum_re[FRAC_W-1:0],
                         sum_im[PW:FRAC_W+DATA_W], sum_im[FRAC_W-1:0]};

endmodule

// File: rtl/sdf_r2_stage_64.sv
// rtl/sdf_r2_stage_64.sv - radix-2 DIF single-path delay-feedback stage, 64-entry complex delay line
module sdf_r2_stage_64
  import fft_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int N_POINTS = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  sdf_r2_stage_64_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(N_POINTS);

  // DEPTH must be a power of two so the pointer wraps naturally
  cplx_t              line_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   out_cnt;
  logic               done;

  cplx_t              x, fifo_out, bfly_sum, bfly_diff, push_val, result;
  logic               in_bfly, in_twid, advance, produce;
  logic signed [DATA_W-1:0] rot_r, rot_i;

  always_comb begin
    x         = '0;
    if (bus.in_valid) begin
      x.re = bus.din_r;
      x.im = bus.din_i;
    end
    in_bfly   = (bus.state == ST_BFLY);
    in_twid   = (bus.state == ST_TWID);
    advance   = in_bfly || in_twid || ((bus.state == ST_FILL) && bus.in_valid);
    produce   = (in_bfly || in_twid) && !done;
    fifo_out  = line_q[wr_ptr];
    bfly_sum  = '0;
    bfly_diff = '0;
    bfly_sum.re  = fifo_out.re + x.re;
    bfly_sum.im  = fifo_out.im + x.im;
    bfly_diff.re = fifo_out.re - x.re;
    bfly_diff.im = fifo_out.im - x.im;
    push_val  = in_bfly ? bfly_diff : x;
    result    = '0;
    if (in_bfly) begin
      result = bfly_sum;
    end else begin
      result.re = rot_r;
      result.im = rot_i;
    end
  end

  cmul_q #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_cmul (
    .a_r (fifo_out.re),
    .a_i (fifo_out.im),
    .w_r (bus.w_r),
    .w_i (bus.w_i),
    .p_r (rot_r),
    .p_i (rot_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
      wr_ptr        <= '0;
      out_cnt       <= '0;
      done          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.dout_r    <= '0;
      bus.dout_i    <= '0;
    end else begin
      if (advance) begin
        line_q[wr_ptr] <= push_val;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (produce) begin
        bus.out_valid <= 1'b1;
        bus.dout_r    <= result.re;
        bus.dout_i    <= result.im;
        out_cnt       <= out_cnt + CNT_W'(1);
        if (out_cnt == CNT_W'(N_POINTS - 1)) begin
          done <= 1'b1;
        end
      end else begin
        bus.out_valid <= 1'b0;
        // Once the frame is complete the output is parked at zero until reset
        if (done) begin
          bus.dout_r <= '0;
          bus.dout_i <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage_64.sv
// tb/tb_sdf_r2_stage_64.sv - scoreboard bench for the 64-deep SDF radix-2 stage
module tb_sdf_r2_stage_64;
  import fft_pkg::*;

  typedef struct {
    logic signed [23:0] re;
    logic signed [23:0] im;
    int                 idx;
  } exp_t;

  logic clk;
  logic rst_n;
  sdf_r2_stage_64_if bus ();

  sdf_r2_stage_64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic signed [23:0] xr [1024];
  logic signed [23:0] xi [1024];
  logic signed [23:0] er [1024];
  logic signed [23:0] ei [1024];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Monitor: pop one expected entry for every valid output
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        valid_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL extra_output got (%0d,%0d) expected no output", bus.dout_r, bus.dout_i);
        end else begin
          mon_e = sb_q.pop_front();
          if (bus.dout_r !== mon_e.re || bus.dout_i !== mon_e.im) begin
            errors++;
            $display("FAIL out[%0d] got (%0d,%0d) expected (%0d,%0d)",
                     mon_e.idx, bus.dout_r, bus.dout_i, mon_e.re, mon_e.im);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    bus.state    = ST_FILL;
    bus.in_valid = 1'b0;
    bus.din_r    = 24'h5A5A5A;
    bus.din_i    = 24'h123456;
    bus.w_r      = 24'h0F0F0F;
    bus.w_i      = 24'h070707;
  endtask

  task automatic set_inputs(input int a);
    int j;
    j = a % 64;
    if (a < 64)                       bus.state = ST_FILL;
    else if (((a - 64) / 64) % 2 == 0) bus.state = ST_BFLY;
    else                              bus.state = ST_TWID;
    bus.in_valid = (a < 1024);
    if (a < 1024) begin
      bus.din_r = xr[a];
      bus.din_i = xi[a];
    end else begin
      bus.din_r = 24'h3C3C3C;
      bus.din_i = 24'h0C0C0C;
    end
    case (j)
      1:       begin bus.w_r = 24'sd256; bus.w_i = -24'sd13; end
      2:       begin bus.w_r = 24'sd255; bus.w_i = -24'sd25; end
      default: begin bus.w_r = 24'sd256; bus.w_i = 24'sd0;   end
    endcase
  endtask

  // Hand-derived stimulus and expected outputs for each directed case
  task automatic prep(input int test);
    for (int k = 0; k < 1024; k++) begin
      xr[k] = '0; xi[k] = '0; er[k] = '0; ei[k] = '0;
    end
    case (test)
      0: begin
        xr[0] = 24'sd256;
        er[0] = 24'sd256; er[64] = 24'sd256;
      end
      1: begin
        for (int k = 0; k < 1024; k++) begin
          xr[k] = 24'sd256;
          if (k % 128 < 64) er[k] = 24'sd512;
        end
      end
      2: begin
        xr[1] = 24'sd256;
        er[1] = 24'sd256; er[65] = 24'sd256; ei[65] = -24'sd13;
      end
      3: begin
        xr[2] = -24'sd1;
        er[2] = -24'sd1; er[66] = -24'sd1;
      end
      default: begin
        xr[0] = 24'h7FFFFF; xr[64] = 24'sd1;
        er[0] = 24'h800000; er[64] = 24'h7FFFFE;
      end
    endcase
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input string name, input int stall_at, input int abort_at);
    exp_t e;
    for (int k = 0; k < 1024; k++) begin
      e.re = er[k]; e.im = ei[k]; e.idx = k;
      sb_q.push_back(e);
    end
    valid_cnt = 0;
    for (int a = 0; a < 1088; a++) begin
      if (a == stall_at) begin
        repeat (5) begin
          @(posedge clk); #1;
          idle_inputs();
        end
      end
      if (a == abort_at) begin
        @(negedge clk);
        check({name, "_valid_before_reset"}, int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check({name, "_reset_valid"}, int'(bus.out_valid), 0);
        check({name, "_reset_dout_r"}, int'(bus.dout_r), 0);
        check({name, "_reset_dout_i"}, int'(bus.dout_i), 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb_q.delete();
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      set_inputs(a);
    end
    repeat (4) begin
      @(posedge clk); #1;
      bus.state    = ST_BFLY;
      bus.in_valid = 1'b1;
      bus.din_r    = 24'sd77;
      bus.din_i    = 24'sd99;
    end
    @(negedge clk);
    check({name, "_valid_cycles"}, valid_cnt, 1024);
    check({name, "_queue_left"}, sb_q.size(), 0);
    check({name, "_post_valid"}, int'(bus.out_valid), 0);
    check({name, "_post_dout_r"}, int'(bus.dout_r), 0);
    check({name, "_post_dout_i"}, int'(bus.dout_i), 0);
    apply_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_dout_r", int'(bus.dout_r), 0);
    check("reset_dout_i", int'(bus.dout_i), 0);
    rst_n = 1'b1;

    prep(0); run_frame("impulse", -1, -1);
    prep(1); run_frame("dc", -1, -1);
    prep(2); run_frame("twiddle", -1, -1);
    prep(3); run_frame("floor", -1, -1);
    prep(4); run_frame("wrap", -1, -1);
    prep(0); run_frame("stall", 10, -1);
    prep(0); run_frame("abort", -1, 84);
    prep(0); run_frame("after_reset", -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
